// File: rtl/ifetch_queue_pkg.sv
// Shared types for the instruction-fetch queue: NOP encoding, state and entry layout.
package ifetch_queue_pkg;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [0:0] {RUN = 1'b0, FAULT = 1'b1} state_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        fault;
  } entry_t;
endpackage

// File: rtl/ifetch_queue_if.sv
// Fetch-side bus: redirect from execute, program-ROM port and decode handshake.
interface ifetch_queue_if;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        rom_en;
  logic [29:0] rom_addr;
  logic [31:0] rom_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;

  modport master (
    input  redirect_valid, redirect_target, rom_data, inst_ready,
    output rom_en, rom_addr, inst_valid, inst, inst_pc, inst_fault
  );
  modport slave (
    output redirect_valid, redirect_target, rom_data, inst_ready,
    input  rom_en, rom_addr, inst_valid, inst, inst_pc, inst_fault
  );
endinterface

// File: rtl/ifetch_queue_fifo.sv
// Power-of-two FIFO of fetched entries; flush wins over pop, and a push coincident
// with a flush lands as the sole entry.
module ifetch_fifo
  import ifetch_queue_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  entry_t                   push_data,
  input  logic                     pop,
  output entry_t                   head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  entry_t         mem [DEPTH];
  logic [AW-1:0]  rd_ptr, wr_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= push ? AW'(1) : AW'(0);
      count  <= push ? CW'(1) : CW'(0);
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[flush ? AW'(0) : wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch front end: credit-limited ROM requests, latency tracker,
// FIFO to decode, and a sticky fault marker for misaligned redirects.
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2,
  parameter int          ROM_LAT  = 1
) (
  input logic            clk,
  input logic            rst,
  ifetch_queue_if.master bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = CW + 1;

  state_e                   state;
  logic [31:0]              pc;
  logic [ROM_LAT:1]         vld_pipe;
  logic [ROM_LAT:1][31:0]   pc_pipe;
  logic [CW-1:0]            q_count;
  logic [SW-1:0]            inflight;
  logic                     q_full, q_empty, push, pop, misaligned, in_run;
  entry_t                   q_head, push_data;

  always_comb begin
    inflight = '0;
    for (int k = 1; k <= ROM_LAT; k++) inflight += SW'(vld_pipe[k]);
  end

  assign misaligned = (bus.redirect_target[1:0] != 2'b00);
  assign in_run     = (state == RUN);

  // Credits count the registered queue occupancy, so a dequeue frees its slot a cycle later.
  assign bus.rom_en   = rst && in_run && !bus.redirect_valid && !q_full &&
                        (SW'(q_count) + inflight < SW'(DEPTH));
  assign bus.rom_addr = pc[31:2];

  // A misaligned redirect reuses the flush+push path to plant the fault marker.
  assign push      = bus.redirect_valid ? misaligned : (in_run && vld_pipe[ROM_LAT]);
  assign push_data = bus.redirect_valid ?
                     entry_t'{inst: NOP, pc: bus.redirect_target, fault: 1'b1} :
                     entry_t'{inst: bus.rom_data, pc: pc_pipe[ROM_LAT], fault: 1'b0};
  assign pop       = bus.inst_valid && bus.inst_ready && in_run;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= RUN;
      pc       <= RESET_PC;
      vld_pipe <= '0;
      pc_pipe  <= '0;
    end else if (bus.redirect_valid) begin
      state    <= misaligned ? FAULT : RUN;
      pc       <= bus.redirect_target;
      vld_pipe <= '0;
    end else begin
      if (bus.rom_en) pc <= pc + 32'd4;
      vld_pipe[1] <= bus.rom_en;
      pc_pipe[1]  <= pc;
      for (int k = 2; k <= ROM_LAT; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        pc_pipe[k]  <= pc_pipe[k-1];
      end
    end
  end

  ifetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.redirect_valid),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (q_head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

  assign bus.inst_valid = !q_empty;
  assign bus.inst       = q_empty ? 32'h0 : q_head.inst;
  assign bus.inst_pc    = q_empty ? 32'h0 : q_head.pc;
  assign bus.inst_fault = q_empty ? 1'b0  : q_head.fault;
endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: random and directed traffic against a queue-based fetch model.
module tb_ifetch_queue;
  localparam int          DEPTH    = 4;
  localparam int          ROM_LAT  = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_W    = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        fault;
  } ment_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ifetch_queue_if bus();

  ifetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH), .ROM_LAT(ROM_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // reference model: pc, fault flag, decode queue, in-flight requests with due cycle
  logic [31:0] m_pc;
  bit          m_fault;
  ment_t       m_q[$];
  logic [31:0] f_pc[$];
  int          f_due[$];
  logic        hist_v [ROM_LAT];
  logic [29:0] hist_a [ROM_LAT];

  logic        e_en, e_valid, e_fault;
  logic [29:0] e_addr;
  logic [31:0] e_inst, e_pc;

  function automatic logic [31:0] rom_word(input logic [29:0] a);
    return {a[15:0], a[29:14]} ^ 32'hC3A5_5A3C;
  endfunction

  function automatic logic [96:0] obs();
    return {bus.rom_en, bus.rom_addr, bus.inst_valid, bus.inst, bus.inst_pc, bus.inst_fault};
  endfunction

  function automatic logic [96:0] expv();
    return {e_en, e_addr, e_valid, e_inst, e_pc, e_fault};
  endfunction

  task automatic model_reset();
    m_q.delete(); f_pc.delete(); f_due.delete();
    m_pc = RESET_PC; m_fault = 0; cyc = 0;
    for (int k = 0; k < ROM_LAT; k++) begin hist_v[k] = 1'b0; hist_a[k] = '0; end
  endtask

  task automatic drive(input logic rv, input logic [31:0] rt, input logic rdy);
    bus.redirect_valid  = rv;
    bus.redirect_target = rt;
    bus.inst_ready      = rdy;
    bus.rom_data        = hist_v[ROM_LAT-1] ? rom_word(hist_a[ROM_LAT-1]) : $urandom;
    #1;
    e_en    = !m_fault && !rv && (m_q.size() + f_pc.size() < DEPTH);
    e_addr  = m_pc[31:2];
    e_valid = (m_q.size() != 0);
    e_inst  = e_valid ? m_q[0].inst  : 32'h0;
    e_pc    = e_valid ? m_q[0].pc    : 32'h0;
    e_fault = e_valid ? m_q[0].fault : 1'b0;
  endtask

  task automatic advance();
    for (int k = ROM_LAT-1; k > 0; k--) begin hist_v[k] = hist_v[k-1]; hist_a[k] = hist_a[k-1]; end
    hist_v[0] = bus.rom_en;
    hist_a[0] = bus.rom_addr;
    if (bus.redirect_valid) begin
      m_q.delete(); f_pc.delete(); f_due.delete();
      m_pc    = bus.redirect_target;
      m_fault = (bus.redirect_target[1:0] != 2'b00);
      if (m_fault) m_q.push_back('{inst: NOP_W, pc: bus.redirect_target, fault: 1'b1});
    end else begin
      if (e_valid && bus.inst_ready && !m_fault) void'(m_q.pop_front());
      if (f_due.size() != 0 && f_due[0] == cyc) begin
        m_q.push_back('{inst: rom_word(f_pc[0][31:2]), pc: f_pc[0], fault: 1'b0});
        void'(f_pc.pop_front()); void'(f_due.pop_front());
      end
      if (e_en) begin
        f_pc.push_back(m_pc); f_due.push_back(cyc + ROM_LAT);
        m_pc = m_pc + 32'd4;
      end
    end
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [96:0] want;
    want = {1'b0, RESET_PC[31:2], 66'b0};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      total++;
      if (obs() !== want) begin bad++; $display("FAIL reset got=%h want=%h", obs(), want); end
    end
    @(negedge clk);
    model_reset();
    rst = 1'b1;
  endtask

  task automatic test_stream();
    int first = -1;
    for (int i = 0; i < 14; i++) begin
      drive(1'b0, 32'h0, 1'b1);
      total++;
      if (obs() !== expv()) begin bad++; $display("FAIL stream cyc=%0d got=%h want=%h", i, obs(), expv()); end
      total++;
      if (bus.rom_addr !== 30'(i)) begin bad++; $display("FAIL stream_addr cyc=%0d got=%h want=%h", i, bus.rom_addr, 30'(i)); end
      if (first < 0 && bus.inst_valid === 1'b1) first = i;
      advance();
    end
    total++;
    if (first != ROM_LAT + 1) begin bad++; $display("FAIL first_valid got=%0d want=%0d", first, ROM_LAT + 1); end
  endtask

  task automatic test_stall();
    int issued = 0, n = 0;
    drive(1'b1, 32'h40, 1'b0);
    total++;
    if (obs() !== expv()) begin bad++; $display("FAIL stall_redir got=%h want=%h", obs(), expv()); end
    advance();
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 32'h0, 1'b0);
      total++;
      if (obs() !== expv()) begin bad++; $display("FAIL stall cyc=%0d got=%h want=%h", i, obs(), expv()); end
      if (bus.rom_en === 1'b1) issued++;
      advance();
    end
    total++;
    if (issued != DEPTH) begin bad++; $display("FAIL stall_issued got=%0d want=%0d", issued, DEPTH); end
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 32'h0, 1'b1);
      total++;
      if (obs() !== expv()) begin bad++; $display("FAIL drain cyc=%0d got=%h want=%h", i, obs(), expv()); end
      if (bus.inst_valid === 1'b1) begin
        total++;
        if (bus.inst_pc !== 32'h40 + 32'(4 * n)) begin
          bad++; $display("FAIL drain_order got=%h want=%h", bus.inst_pc, 32'h40 + 32'(4 * n));
        end
        n++;
      end
      advance();
    end
    total++;
    if (n < DEPTH) begin bad++; $display("FAIL drain_count got=%0d want>=%0d", n, DEPTH); end
  endtask

  task automatic seq_check(input string name, input logic [31:0] start, input int cycles, input int min_n);
    int n = 0;
    logic [31:0] want;
    for (int i = 0; i < cycles; i++) begin
      drive(1'b0, 32'h0, 1'b1);
      total++;
      if (obs() !== expv()) begin bad++; $display("FAIL %s cyc=%0d got=%h want=%h", name, i, obs(), expv()); end
      if (bus.inst_valid === 1'b1) begin
        want = start + 32'(4 * n);
        total++;
        if (bus.inst_pc !== want || bus.inst_fault !== 1'b0) begin
          bad++; $display("FAIL %s_pc got=%h want=%h", name, bus.inst_pc, want);
        end
        n++;
      end
      advance();
    end
    total++;
    if (n < min_n) begin bad++; $display("FAIL %s_count got=%0d want>=%0d", name, n, min_n); end
  endtask

  task automatic test_redirect_inflight();
    for (int i = 0; i < 4; i++) begin drive(1'b0, 32'h0, 1'b1); advance(); end
    drive(1'b1, 32'h100, 1'b1);
    total++;
    if (obs() !== expv()) begin bad++; $display("FAIL redir got=%h want=%h", obs(), expv()); end
    advance();
    seq_check("redir", 32'h100, 8, 3);
  endtask

  task automatic test_fault();
    logic [97:0] want;
    drive(1'b1, 32'h102, 1'b1);
    advance();
    want = {1'b1, NOP_W, 32'h102, 1'b1, 1'b0, 30'(32'h102 >> 2)};
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 32'h0, 1'b1);
      total++;
      if ({bus.inst_valid, bus.inst, bus.inst_pc, bus.inst_fault, bus.rom_en, bus.rom_addr} !== want) begin
        bad++; $display("FAIL fault_hold cyc=%0d got=%h want=%h", i,
          {bus.inst_valid, bus.inst, bus.inst_pc, bus.inst_fault, bus.rom_en, bus.rom_addr}, want);
      end
      advance();
    end
    drive(1'b1, 32'h207, 1'b0);
    advance();
    drive(1'b0, 32'h0, 1'b1);
    total++;
    if (bus.inst_pc !== 32'h207 || bus.inst_fault !== 1'b1 || bus.inst !== NOP_W) begin
      bad++; $display("FAIL fault_replace got=%h want=%h", bus.inst_pc, 32'h207);
    end
    advance();
    drive(1'b1, 32'h200, 1'b1);
    advance();
    seq_check("resume", 32'h200, 8, 3);
  endtask

  task automatic test_wrap();
    drive(1'b1, 32'hFFFF_FFF8, 1'b1);
    advance();
    seq_check("wrap", 32'hFFFF_FFF8, 8, 3);
  endtask

  task automatic test_random();
    logic        rv;
    logic [31:0] rt;
    for (int i = 0; i < 400; i++) begin
      rv = ($urandom_range(0, 11) == 0);
      case ($urandom_range(0, 3))
        0: rt = $urandom & 32'hFFFF_FFFC;
        1: rt = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3));
        2: rt = 32'hFFFF_FFF0 | (32'($urandom_range(0, 3)) << 2);
        default: rt = 32'h1000;
      endcase
      drive(rv, rt, $urandom_range(0, 3) != 0);
      total++;
      if (obs() !== expv()) begin bad++; $display("FAIL random cyc=%0d got=%h want=%h", i, obs(), expv()); end
      advance();
    end
  endtask

  task automatic test_async_reset();
    logic [96:0] want;
    want = {1'b0, RESET_PC[31:2], 66'b0};
    drive(1'b1, 32'h300, 1'b1);
    advance();
    for (int i = 0; i < 4; i++) begin drive(1'b0, 32'h0, 1'b1); advance(); end
    drive(1'b0, 32'h0, 1'b1);
    #2 rst = 1'b0;
    #1;
    total++;
    if (obs() !== want) begin bad++; $display("FAIL async_reset got=%h want=%h", obs(), want); end
    @(negedge clk); #1;
    total++;
    if (obs() !== want) begin bad++; $display("FAIL reset_hold got=%h want=%h", obs(), want); end
    @(negedge clk);
    model_reset();
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b1);
    total++;
    if (bus.rom_en !== 1'b1 || bus.rom_addr !== RESET_PC[31:2]) begin
      bad++; $display("FAIL restart got=%b/%h want=1/%h", bus.rom_en, bus.rom_addr, RESET_PC[31:2]);
    end
    advance();
    seq_check("restart", RESET_PC + 32'd4 - 32'd4, 10, 3);
  endtask

  initial begin
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = 32'h0;
    bus.inst_ready      = 1'b0;
    bus.rom_data        = 32'h0;
    model_reset();
    test_reset();
    test_stream();
    test_stall();
    test_redirect_inflight();
    test_fault();
    test_wrap();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
